vote_sampler: RTL and testbench
===============================

# vote_sampler

Front-end stage for the three-input majority voter. Takes three raw voter buttons and yes/no switches, synchronizes and debounces them, and runs a ballot state machine that captures one vote per voter. It presents the captured votes as stable `a`, `b`, `c` levels with a `valid` flag to the downstream majority stage.

## Interface
Parameters:
- `DB_CYCLES`, default 4: number of consecutive synchronized samples that must differ from the debounced level before that level flips. Legal range 2–255.
- `TIMEOUT`, default 255: length of the ballot window in COLLECT cycles. Legal range 2–65535.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  synchronous one-cycle pulse that opens a ballot.
- `vote_en`  in  3  raw, asynchronous per-voter cast buttons. Bit 2 is voter A, bit 1 is voter B, bit 0 is voter C.
- `vote_val`  in  3  raw, asynchronous per-voter yes(1)/no(0) switches, same bit mapping as `vote_en`.
- `a`, `b`, `c`  out  1 each  captured votes of voters A, B, C; these feed the majority stage.
- `valid`  out  1  high while a completed ballot is held.
- `cast`  out  3  voters that have cast in the current ballot.
- `timed_out`  out  1  the held ballot closed on timeout.
- `busy`  out  1  high while in COLLECT.

## Operation
- **Synchronizer.** Two-flop synchronizer on each of the six raw bits; flops reset to 0.
- **Debounce.** One counter per bit.
  - Each cycle the synchronized value differs from the debounced level, the counter increments.
  - Any cycle it matches, the counter clears.
  - When the counter reaches DB_CYCLES−1 while still differing, the debounced level flips on that edge and the counter clears.
  - Debounced levels reset to 0.
- **Cast event.** A cast event for voter i is a rising edge of the debounced `vote_en[i]` (debounced level high, previous-cycle level low). It is a one-cycle internal strobe.
- **States:** IDLE, COLLECT, DONE. Reset state is IDLE.
- **IDLE:**
  - `start` → COLLECT. `cast`, the vote registers, `timed_out` and the timer all clear to 0.
  - Cast events are ignored.
- **COLLECT:**
  - On a cast event for voter i with `cast[i]`=0: capture debounced `vote_val[i]` into the vote register and set `cast[i]`. Multiple voters may cast in the same cycle; each is captured.
  - Repeat casts from a voter that has already cast are ignored; the first vote stands.
  - If the cycle's captures make `cast`=3'b111 → DONE with `timed_out`=0.
  - Otherwise, if the timer equals TIMEOUT−1 → DONE with `timed_out`=1. Voters that did not cast hold vote 0.
  - Otherwise the timer increments.
  - If the third cast and the timer expiry happen in the same cycle, the completed ballot wins: `timed_out`=0.
  - `start` is ignored.
- **DONE:**
  - `a`/`b`/`c`, `cast` and `timed_out` are frozen, and cast events are ignored.
  - `start` → COLLECT with the same clears as from IDLE.
- **Outputs:**
  - `valid` = (state==DONE).
  - `busy` = (state==COLLECT).
  - `a`/`b`/`c` come straight from the vote registers. They are meaningful to the majority stage only while `valid`=1.
- **Widths:** the timer is 16 bits; the debounce counters are 8 bits. Counters never wrap, because they clear at their limits.

## Timing
- **Reset.** Asserting `rst_n`=0 at any time, including mid-ballot, immediately forces all of the following to 0 and the state to IDLE: `a`, `b`, `c`, `valid`, `cast`, `timed_out`, `busy`, all synchronizer flops, debounced levels, counters and the timer. After release, no cast event is produced unless a raw input is actually pressed.
- **Cast latency.**
  - Let E be the first edge that samples raw `vote_en[i]` high, with the input stable from then on.
  - The debounced level rises on edge E+1+DB_CYCLES.
  - `cast[i]` and the vote bit update on edge E+2+DB_CYCLES.
  - The captured vote is the debounced `vote_val[i]` level at that edge.
- **Glitch rejection.** Raw pulses shorter than DB_CYCLES synchronized samples produce no cast.
- **Start latency.** A `start` sampled at edge S puts the block in COLLECT at S: `busy`=1 and `valid`=0 after S.
- **Completion.** `valid` rises on the same edge that sets the third `cast` bit.
- **Timeout.** If no completion occurs, DONE is entered on the TIMEOUT-th edge after entering COLLECT.
- **Holding.** DONE holds indefinitely until the next `start` or a reset.

## Test plan
- **Reset.** `rst_n` low with random inputs → every output 0. Release with inputs low for 20 cycles → no change.
- **Full ballot (DB_CYCLES=4).** `start`; A presses with `vote_val`=1, then B with 0, then C with 1, spaced 20 cycles apart → `cast` goes 100, 110, 111. `valid` rises with the third cast. {a,b,c}=101, `timed_out`=0, and each cast lands exactly 6 edges after its press edge.
- **Bounce and repeat.** A 3-cycle glitch on `vote_en[1]` → no cast. A then presses, releases and re-presses with `vote_val` flipped → the first value is retained and `cast[2]` is set once.
- **Timeout (TIMEOUT=50).** `start`; only voter C casts with value 1 → DONE after 50 cycles in COLLECT. `timed_out`=1, `cast`=001, {a,b,c}=001.
- **Simultaneous events.** A and B cast early; C's cast is captured on the edge where the timer equals TIMEOUT−1 → `timed_out`=0 and `valid`=1. Separately, all three cast in the same cycle → `cast` jumps 000→111 in one edge.
- **Reset mid-ballot and restart.** Assert `rst_n` in COLLECT with `cast`=110 → all outputs 0 immediately. Then `start` in DONE → `valid` drops, `cast` clears and a new ballot runs.

Source files
------------

// File: rtl/vote_sampler.sv
// vote_sampler: front-end for the three-input majority voter.
// Synchronizes and debounces raw cast buttons and yes/no switches, then runs
// a ballot FSM that captures one vote per voter for the majority stage.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     one-cycle pulse that opens a ballot (ignored in COLLECT)
//   vote_en   raw cast buttons   [2]=A [1]=B [0]=C
//   vote_val  raw yes/no switches, same mapping as vote_en
//   a, b, c   captured votes of voters A, B, C
//   valid     high while a completed ballot is held (DONE)
//   cast      voters that have cast in the current ballot
//   timed_out held ballot closed on timeout
//   busy      high while collecting votes
module vote_sampler #(
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] vote_en,
    input  logic [2:0] vote_val,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       valid,
    output logic [2:0] cast,
    output logic       timed_out,
    output logic       busy
);

    localparam int unsigned NB = 6;
    localparam int unsigned CW = 8;
    localparam int unsigned TW = 16;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    logic [NB-1:0] raw;
    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [NB-1:0] db;
    logic [CW-1:0] db_cnt [NB];
    logic [2:0]    en_q;
    logic [2:0]    en_db;
    logic [2:0]    val_db;
    logic [2:0]    cast_ev;

    state_t        state;
    state_t        state_n;
    logic [2:0]    cast_n;
    logic [2:0]    votes;
    logic [2:0]    votes_n;
    logic          timed_out_n;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_n;
    logic [2:0]    new_cast;

    assign raw    = {vote_en, vote_val};
    assign en_db  = db[5:3];
    assign val_db = db[2:0];
    // One-cycle strobe on the rising edge of each debounced cast button
    assign cast_ev = en_db & ~en_q;

    // Two-flop synchronizer on all six raw inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Per-bit debounce: flip after DB_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db   <= '0;
            en_q <= '0;
            for (int i = 0; i < NB; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            en_q <= en_db;
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] != db[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        db[i]     <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Ballot FSM next-state and next-register values
    always_comb begin
        state_n     = state;
        cast_n      = cast;
        votes_n     = votes;
        timed_out_n = timed_out;
        timer_n     = timer;
        new_cast    = '0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_n     = S_COLLECT;
                    cast_n      = '0;
                    votes_n     = '0;
                    timed_out_n = 1'b0;
                    timer_n     = '0;
                end
            end
            S_COLLECT: begin
                // Only first casts count; the first vote stands
                new_cast = cast_ev & ~cast;
                cast_n   = cast | new_cast;
                votes_n  = (votes & ~new_cast) | (val_db & new_cast);
                // A completed ballot wins over a coincident timeout
                if (cast_n == 3'b111) begin
                    state_n     = S_DONE;
                    timed_out_n = 1'b0;
                end else if (timer == TO_LAST) begin
                    state_n     = S_DONE;
                    timed_out_n = 1'b1;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Ballot state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cast      <= '0;
            votes     <= '0;
            timed_out <= 1'b0;
            timer     <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cast      <= cast_n;
            votes     <= votes_n;
            timed_out <= timed_out_n;
            timer     <= timer_n;
            valid     <= (state_n == S_DONE);
            busy      <= (state_n == S_COLLECT);
        end
    end

    assign a = votes[2];
    assign b = votes[1];
    assign c = votes[0];

endmodule

// File: tb/tb_vote_sampler.sv
// Directed bench for vote_sampler (DB_CYCLES=4, TIMEOUT=50).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Output vector layout: {a, b, c, valid, cast[2:0], timed_out, busy}.
module tb_vote_sampler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] vote_en;
    logic [2:0] vote_val;
    logic       a;
    logic       b;
    logic       c;
    logic       valid;
    logic [2:0] cast;
    logic       timed_out;
    logic       busy;
    logic [8:0] outs;

    int total = 0;
    int bad   = 0;

    vote_sampler #(
        .DB_CYCLES(4),
        .TIMEOUT  (50)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .vote_en  (vote_en),
        .vote_val (vote_val),
        .a        (a),
        .b        (b),
        .c        (c),
        .valid    (valid),
        .cast     (cast),
        .timed_out(timed_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    assign outs = {a, b, c, valid, cast, timed_out, busy};

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        ticks(1);
        start = 1'b0;
    endtask

    task automatic check(input string tag, input logic [8:0] expv);
        total++;
        assert (outs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%b required=%b", tag, outs, expv);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        vote_en  = 3'($urandom);
        vote_val = 3'($urandom);

        // Reset with random inputs, then release with inputs low
        ticks(3);
        check("reset_random_inputs", 9'b000_0_000_0_0);
        vote_en  = '0;
        vote_val = '0;
        ticks(1);
        rst_n = 1'b1;
        ticks(20);
        check("post_reset_quiet", 9'b000_0_000_0_0);

        // Full ballot: A=1, B=0, C=1, presses 20 cycles apart
        vote_val = 3'b101;
        ticks(8);
        check("idle_before_start", 9'b000_0_000_0_0);
        pulse_start();
        check("start_to_collect", 9'b000_0_000_0_1);
        vote_en = 3'b100;
        ticks(6);
        check("a_cast_not_yet", 9'b000_0_000_0_1);
        ticks(1);
        check("a_cast_lands", 9'b100_0_100_0_1);
        vote_en = 3'b000;
        ticks(13);
        vote_en = 3'b010;
        ticks(6);
        check("b_cast_not_yet", 9'b100_0_100_0_1);
        ticks(1);
        check("b_cast_lands", 9'b100_0_110_0_1);
        vote_en = 3'b000;
        ticks(13);
        vote_en = 3'b001;
        ticks(6);
        check("c_cast_not_yet", 9'b100_0_110_0_1);
        ticks(1);
        check("ballot_complete", 9'b101_1_111_0_0);
        vote_en = 3'b000;
        ticks(10);
        check("done_holds", 9'b101_1_111_0_0);

        // Restart from DONE; glitch rejection and repeat-cast
        pulse_start();
        check("restart_from_done", 9'b000_0_000_0_1);
        vote_en = 3'b010;
        ticks(3);
        vote_en = 3'b000;
        ticks(10);
        check("glitch_rejected", 9'b000_0_000_0_1);
        vote_en = 3'b100;
        ticks(7);
        check("a_first_cast", 9'b100_0_100_0_1);
        vote_en = 3'b000;
        ticks(8);
        vote_val = 3'b001;
        ticks(8);
        vote_en = 3'b100;
        ticks(10);
        check("a_repeat_ignored", 9'b100_0_100_0_1);
        vote_en = 3'b000;
        ticks(4);
        check("bounce_ballot_timeout", 9'b100_1_100_1_0);

        // Timeout with only C casting; start inside COLLECT is ignored
        pulse_start();
        vote_en = 3'b001;
        ticks(7);
        check("c_only_cast", 9'b001_0_001_0_1);
        vote_en = 3'b000;
        ticks(13);
        pulse_start();
        ticks(28);
        check("timeout_not_yet", 9'b001_0_001_0_1);
        ticks(1);
        check("timeout_done", 9'b001_1_001_1_0);

        // Third cast coincides with timer expiry: completion wins
        vote_val = 3'b011;
        ticks(8);
        pulse_start();
        vote_en = 3'b110;
        ticks(7);
        check("ab_cast_early", 9'b010_0_110_0_1);
        ticks(36);
        vote_en = 3'b111;
        ticks(6);
        check("c_late_not_yet", 9'b010_0_110_0_1);
        ticks(1);
        check("complete_beats_timeout", 9'b011_1_111_0_0);

        // All three voters cast in the same cycle
        vote_en  = 3'b000;
        vote_val = 3'b010;
        ticks(8);
        pulse_start();
        vote_en = 3'b111;
        ticks(6);
        check("simul_not_yet", 9'b000_0_000_0_1);
        ticks(1);
        check("simul_all_cast", 9'b010_1_111_0_0);

        // Reset mid-ballot, then a fresh ballot from IDLE
        vote_en  = 3'b000;
        vote_val = 3'b110;
        ticks(8);
        pulse_start();
        vote_en = 3'b110;
        ticks(7);
        check("pre_reset_collect", 9'b110_0_110_0_1);
        rst_n = 1'b0;
        #2;
        check("reset_mid_ballot", 9'b000_0_000_0_0);
        vote_en  = 3'b000;
        vote_val = 3'b000;
        ticks(3);
        rst_n = 1'b1;
        ticks(20);
        check("post_reset_no_cast", 9'b000_0_000_0_0);
        pulse_start();
        check("start_after_reset", 9'b000_0_000_0_1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
